// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing, derived sync bounds, controller states and test-pattern colors.
package vga_timing_pkg;
  localparam int H_ACT = 640;
  localparam int H_FP = 16;
  localparam int H_SW = 96;
  localparam int H_BP = 48;
  localparam int V_ACT = 480;
  localparam int V_FP = 10;
  localparam int V_SH = 2;
  localparam int V_BP = 33;
  localparam int H_TOTAL = H_ACT + H_FP + H_SW + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SH + V_BP;
  localparam int H_SYNC_START = H_ACT + H_FP;
  localparam int H_SYNC_END = H_SYNC_START + H_SW;
  localparam int V_SYNC_START = V_ACT + V_FP;
  localparam int V_SYNC_END = V_SYNC_START + V_SH;
  typedef enum logic {S_IDLE, S_RUN} state_t;
  localparam logic [23:0] C_WHITE = 24'hFFFFFF;
  localparam logic [23:0] C_YELLOW = 24'hFFFF00;
  localparam logic [23:0] C_CYAN = 24'h00FFFF;
  localparam logic [23:0] C_GREEN = 24'h00FF00;
  localparam logic [23:0] C_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] C_RED = 24'hFF0000;
  localparam logic [23:0] C_BLUE = 24'h0000FF;
  localparam logic [23:0] C_BLACK = 24'h000000;
  // Bar 0 (leftmost) is the lowest element.
  localparam logic [7:0][23:0] C_BARS = {C_BLACK, C_BLUE, C_RED, C_MAGENTA, C_GREEN, C_CYAN, C_YELLOW, C_WHITE};
endpackage

// File: rtl/vga_sync_counter.sv
// vga_sync_counter: horizontal/vertical position counters with wrap, plus active-area and sync decode.
module vga_sync_counter import vga_timing_pkg::*; #(
  parameter int P_HACT = H_ACT,
  parameter int P_H_TOTAL = H_TOTAL,
  parameter int P_H_SYNC_START = H_SYNC_START,
  parameter int P_H_SYNC_END = H_SYNC_END,
  parameter int P_VACT = V_ACT,
  parameter int P_V_TOTAL = V_TOTAL,
  parameter int P_V_SYNC_START = V_SYNC_START,
  parameter int P_V_SYNC_END = V_SYNC_END,
  parameter int P_HW = $clog2(P_H_TOTAL),
  parameter int P_VW = $clog2(P_V_TOTAL)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_run,
  input  logic            i_clr,
  output logic [P_HW-1:0] o_h_count,
  output logic [P_VW-1:0] o_v_count,
  output logic            o_active,
  output logic            o_hsync,
  output logic            o_vsync
);
  logic [P_HW-1:0] r_h;
  logic [P_VW-1:0] r_v;
  logic w_h_last;
  logic w_v_last;
  assign w_h_last = int'(r_h) == P_H_TOTAL - 1;
  assign w_v_last = int'(r_v) == P_V_TOTAL - 1;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (i_clr) begin
      r_h <= '0;
      r_v <= '0;
    end else if (i_run) begin
      r_h <= w_h_last ? '0 : r_h + 1'b1;
      if (w_h_last) r_v <= w_v_last ? '0 : r_v + 1'b1;
    end
  end
  assign o_h_count = r_h;
  assign o_v_count = r_v;
  assign o_active = int'(r_h) < P_HACT && int'(r_v) < P_VACT;
  assign o_hsync = int'(r_h) >= P_H_SYNC_START && int'(r_h) < P_H_SYNC_END;
  assign o_vsync = int'(r_v) >= P_V_SYNC_START && int'(r_v) < P_V_SYNC_END;
endmodule

// File: rtl/vga_output_generator.sv
// vga_output_generator: VGA timing, frame-buffer read requests and latency-aligned pixel/sync/DE output.
// Define VGA_TEST_PATTERN_EN to add I_TEST_PATTERN, which replaces pixel data with eight color bars.
module vga_output_generator import vga_timing_pkg::*; #(
  parameter int P_COLUMNS = 640,
  parameter int P_ROWS = 480,
  parameter int P_PIXEL_DEPTH = 24,
  parameter int P_HACT = H_ACT,
  parameter int P_HFP = H_FP,
  parameter int P_HSW = H_SW,
  parameter int P_HBP = H_BP,
  parameter int P_VACT = V_ACT,
  parameter int P_VFP = V_FP,
  parameter int P_VSH = V_SH,
  parameter int P_VBP = V_BP,
  parameter int P_READ_LATENCY = 1
) (
  input  logic                         I_CLK,
  input  logic                         I_RESET,
  input  logic                         I_ENABLE,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                         I_TEST_PATTERN,
`endif
  input  logic [P_PIXEL_DEPTH-1:0]     I_PIXEL,
  output logic [$clog2(P_COLUMNS)-1:0] O_PIXEL_COL,
  output logic [$clog2(P_ROWS)-1:0]    O_PIXEL_ROW,
  output logic                         O_PIXEL_READ_ENABLE,
  output logic [P_PIXEL_DEPTH-1:0]     O_PIX_DATA,
  output logic                         O_HSYNC,
  output logic                         O_VSYNC,
  output logic                         O_DE,
  output logic                         O_FRAME_START
);
  localparam int L = P_READ_LATENCY;
  localparam int HT = P_HACT + P_HFP + P_HSW + P_HBP;
  localparam int VT = P_VACT + P_VFP + P_VSH + P_VBP;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);
  localparam int CW = $clog2(P_COLUMNS);
  localparam int RW = $clog2(P_ROWS);
  state_t r_state;
  state_t w_state_nx;
  logic w_go;
  logic w_tp;
  logic w_rd;
  logic [HW-1:0] w_h;
  logic [VW-1:0] w_v;
  logic w_active;
  logic w_hsync;
  logic w_vsync;
  logic r_act;
  logic r_hs;
  logic r_vs;
  logic r_fs;
  logic [L:0] r_de_d;
  logic [L:0] r_hs_d;
  logic [L:0] r_vs_d;
  logic [L:0] r_fs_d;
  logic [P_PIXEL_DEPTH-1:0] r_pix;
  logic [P_PIXEL_DEPTH-1:0] w_pix_nx;
  always_ff @(posedge I_CLK or negedge I_RESET) begin
    if (!I_RESET) r_state <= S_IDLE;
    else r_state <= w_state_nx;
  end
  always_comb begin
    w_state_nx = r_state;
    w_state_nx = (r_state == S_IDLE) ? (I_ENABLE ? S_RUN : S_IDLE) : (I_ENABLE ? S_RUN : S_IDLE);
  end
  // Dropping the enable clears counters and pipeline on the same edge the FSM returns to idle.
  assign w_go = (r_state == S_RUN) && I_ENABLE;
`ifdef VGA_TEST_PATTERN_EN
  assign w_tp = I_TEST_PATTERN;
`else
  assign w_tp = 1'b0;
`endif
  assign w_rd = w_go && w_active && !w_tp;
  vga_sync_counter #(
    .P_HACT(P_HACT),
    .P_H_TOTAL(HT),
    .P_H_SYNC_START(P_HACT + P_HFP),
    .P_H_SYNC_END(P_HACT + P_HFP + P_HSW),
    .P_VACT(P_VACT),
    .P_V_TOTAL(VT),
    .P_V_SYNC_START(P_VACT + P_VFP),
    .P_V_SYNC_END(P_VACT + P_VFP + P_VSH),
    .P_HW(HW),
    .P_VW(VW)
  ) u_sync_counter (
    .i_clk(I_CLK),
    .i_rst_n(I_RESET),
    .i_run(w_go),
    .i_clr(!I_ENABLE),
    .o_h_count(w_h),
    .o_v_count(w_v),
    .o_active(w_active),
    .o_hsync(w_hsync),
    .o_vsync(w_vsync)
  );
  always_ff @(posedge I_CLK or negedge I_RESET) begin
    if (!I_RESET) begin
      r_act <= 1'b0;
      r_hs <= 1'b0;
      r_vs <= 1'b0;
      r_fs <= 1'b0;
      O_PIXEL_READ_ENABLE <= 1'b0;
      O_PIXEL_COL <= '0;
      O_PIXEL_ROW <= '0;
    end else begin
      r_act <= w_go && w_active;
      r_hs <= w_go && w_hsync;
      r_vs <= w_go && w_vsync;
      r_fs <= w_go && w_active && w_h == '0 && w_v == '0;
      O_PIXEL_READ_ENABLE <= w_rd;
      O_PIXEL_COL <= w_rd ? CW'(w_h) : '0;
      O_PIXEL_ROW <= w_rd ? RW'(w_v) : '0;
    end
  end
`ifdef VGA_TEST_PATTERN_EN
  logic [HW-1:0] r_h_rd;
  logic [HW-1:0] r_h_d [L];
  logic [2:0] w_bar;
  assign w_bar = 3'(int'(r_h_d[L-1]) / (P_HACT / 8));
  always_ff @(posedge I_CLK or negedge I_RESET) begin
    if (!I_RESET || !I_ENABLE) begin
      r_h_rd <= '0;
      for (int k = 0; k < L; k++) r_h_d[k] <= '0;
    end else begin
      r_h_rd <= w_h;
      r_h_d[0] <= r_h_rd;
      for (int k = 1; k < L; k++) r_h_d[k] <= r_h_d[k-1];
    end
  end
`endif
  // Stage L-1 of the DE line lines up with I_PIXEL answering the matching read.
  always_comb begin
    w_pix_nx = r_de_d[L-1] ? I_PIXEL : '0;
`ifdef VGA_TEST_PATTERN_EN
    if (r_de_d[L-1] && I_TEST_PATTERN) w_pix_nx = P_PIXEL_DEPTH'(C_BARS[w_bar]);
`endif
  end
  always_ff @(posedge I_CLK or negedge I_RESET) begin
    if (!I_RESET) begin
      r_de_d <= '0;
      r_hs_d <= '0;
      r_vs_d <= '0;
      r_fs_d <= '0;
      r_pix <= '0;
    end else if (!I_ENABLE) begin
      r_de_d <= '0;
      r_hs_d <= '0;
      r_vs_d <= '0;
      r_fs_d <= '0;
      r_pix <= '0;
    end else begin
      r_de_d <= {r_de_d[L-1:0], r_act};
      r_hs_d <= {r_hs_d[L-1:0], r_hs};
      r_vs_d <= {r_vs_d[L-1:0], r_vs};
      r_fs_d <= {r_fs_d[L-1:0], r_fs};
      r_pix <= w_pix_nx;
    end
  end
  assign O_DE = r_de_d[L];
  assign O_HSYNC = r_hs_d[L];
  assign O_VSYNC = r_vs_d[L];
  assign O_FRAME_START = r_fs_d[L];
  assign O_PIX_DATA = r_pix;
endmodule

// File: doc/vga_output_generator.md
Name: vga_output_generator

Overview:
Transmit side of the VGA pixel interface. The block generates horizontal and vertical timing and issues row/column read requests to the frame buffer. It then drives pixel data, HSYNC, VSYNC and DE so that a downstream VGA/DVI encoder can display the processed (grayscale/edge) frame. It sits between the frame buffer read port and the video output pins.

Parameters:
P_COLUMNS, 640, frame columns; sets the width of O_PIXEL_COL ($clog2).
P_ROWS, 480, frame rows; sets the width of O_PIXEL_ROW ($clog2).
P_PIXEL_DEPTH, 24, pixel data width.
P_HACT / P_HFP / P_HSW / P_HBP, 640 / 16 / 96 / 48, horizontal active, front porch, sync width, back porch (pixels).
P_VACT / P_VFP / P_VSH / P_VBP, 480 / 10 / 2 / 33, vertical active, front porch, sync height, back porch (lines).
P_READ_LATENCY, 1, cycles from a read request being visible to I_PIXEL being valid; range 1..4.

Ports:
I_CLK  in  1  pixel clock; one pixel per cycle while running.
I_RESET  in  1  asynchronous, active-low reset (asserted at 0).
I_ENABLE  in  1  run enable.
I_PIXEL  in  P_PIXEL_DEPTH  frame buffer read data.
O_PIXEL_COL  out  $clog2(P_COLUMNS)  read column.
O_PIXEL_ROW  out  $clog2(P_ROWS)  read row.
O_PIXEL_READ_ENABLE  out  1  read request strobe.
O_PIX_DATA  out  P_PIXEL_DEPTH  output pixel.
O_HSYNC  out  1  horizontal sync, active-high.
O_VSYNC  out  1  vertical sync, active-high.
O_DE  out  1  data enable.
O_FRAME_START  out  1  one-cycle pulse, first active pixel of each frame.

Behaviour:
- Reset: all outputs 0; h_count = v_count = 0; FSM in S_IDLE.
- FSM states: S_IDLE and S_RUN. S_IDLE -> S_RUN when I_ENABLE = 1. S_RUN -> S_IDLE when I_ENABLE = 0; that transition clears the counters and the delay pipeline the same cycle, so the next run starts at (0,0).
- Counters:
  - h_count runs 0..H_TOTAL-1, where H_TOTAL = HACT+HFP+HSW+HBP (800).
  - At h_count = H_TOTAL-1, h_count wraps to 0 and v_count increments.
  - v_count wraps to 0 after V_TOTAL-1, where V_TOTAL = VACT+VFP+VSH+VBP (525).
  - Line order: active, front porch, sync, back porch. Vertical order is the same.
- Read request (registered, one cycle after the counter value):
  - O_PIXEL_READ_ENABLE = 1 only when h_count < HACT and v_count < VACT.
  - While enabled, COL = h_count and ROW = v_count; when not enabled, both are 0.
- Alignment:
  - Raw DE, HSYNC and VSYNC pass through a delay line of P_READ_LATENCY+1 stages.
  - O_PIX_DATA, O_DE, O_HSYNC and O_VSYNC appear exactly P_READ_LATENCY+1 cycles after the matching read request.
  - O_PIX_DATA = registered I_PIXEL when delayed DE = 1, otherwise 0.
- Sync timing:
  - HSYNC high for HACT+HFP <= h_count < HACT+HFP+HSW (656..751).
  - VSYNC high for VACT+VFP <= v_count < VACT+VFP+VSH (490..491) on whole lines.
- O_FRAME_START is high together with O_DE for pixel (0,0) only.
- Internal counters are 32-bit (or $clog2(total)). Output address truncation is legal because COL/ROW are only driven inside the active region.
- Async reset mid-frame: outputs drop to 0 immediately; no partial-frame recovery.

Optional Feature:
VGA_TEST_PATTERN_EN.
- Defined: adds input I_TEST_PATTERN (1 bit). While it is high, O_PIX_DATA shows 8 vertical color bars of width HACT/8: white, yellow, cyan, green, magenta, red, blue, black. The bars are derived from the delayed h_count. O_PIXEL_READ_ENABLE stays 0, and timing is unchanged.
- Undefined: the port and logic are absent, and output always comes from I_PIXEL.

Decomposition:
- Package vga_timing_pkg holds:
  - the default timing constants;
  - derived H_TOTAL, V_TOTAL, H_SYNC_START/END and V_SYNC_START/END;
  - the FSM state enum {S_IDLE, S_RUN};
  - the test-pattern color constants.
- One natural sub-module, vga_sync_counter: h/v counters with wrap, plus the active, hsync and vsync decode flags.

Test Plan:
- Reset low for 3 cycles, then release with I_ENABLE = 0 -> all outputs 0 indefinitely; FSM stays in S_IDLE.
- I_ENABLE = 1 and frame buffer model with latency 1 returning {row,col} -> first read (0,0) one cycle after enable; O_DE and O_PIX_DATA = pixel(0,0) 2 cycles after that; O_FRAME_START high the same cycle.
- Run one full frame -> exactly 800x525 cycles per frame; 640 DE cycles per active line; HSYNC pulses 96 wide starting at column 656; VSYNC high on lines 490–491 only; 307200 reads per frame.
- P_READ_LATENCY = 3 -> O_DE is delayed 4 cycles after each read request, and every output pixel matches its requested address.
- Drop I_ENABLE at line 100, column 300, then reassert -> outputs zero within one cycle; restart from (0,0) with a fresh O_FRAME_START.
- VGA_TEST_PATTERN_EN defined, I_TEST_PATTERN = 1 -> O_PIX_DATA = 24'hFFFFFF for columns 0..79 and 24'hFFFF00 for columns 80..159; O_PIXEL_READ_ENABLE stays 0.
